// File: rtl/axi_warb_pkg.sv
// Shared definitions for the two-manager AXI-lite write arbiter.
package axi_warb_pkg;

    localparam int ID_W   = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int ATOP_W = 6;
    localparam int CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AW   = 2'd1,
        W    = 2'd2,
        B    = 2'd3
    } warb_state_e;

    // Beat counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/axi_write_arbiter_rr_arb2.sv
// Two-input picker: a lone requester always wins; on a tie the pointer
// decides, or manager 0 wins when fixed_prio is set.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    input  logic       fixed_prio,
    output logic       grant
);

    // Select the winning manager index from the request pair.
    always_comb begin
        grant = 1'b0;
        case (req)
            2'b10:   grant = 1'b1;
            2'b11:   grant = fixed_prio ? 1'b0 : ptr;
            default: grant = 1'b0;
        endcase
    end

endmodule

// File: rtl/axi_write_arbiter.sv
// Two-manager to one-subordinate AXI-lite write arbiter. One transaction is
// in flight at a time; the grant is held from AW acceptance through B.
// Define AXI_WARB_FIXED_PRIO_EN for fixed priority (manager 0 wins ties);
// otherwise ties alternate round-robin.
module axi_write_arbiter #(
    parameter int NUM_M = 2,
    parameter int ID_W  = axi_warb_pkg::ID_W
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NUM_M-1:0]                       m_awvalid,
    output logic [NUM_M-1:0]                       m_awready,
    input  logic [NUM_M*ID_W-1:0]                  m_awid,
    input  logic [NUM_M*axi_warb_pkg::ADDR_W-1:0]  m_awaddr,
    input  logic [NUM_M*axi_warb_pkg::ATOP_W-1:0]  m_awatop,
    input  logic [NUM_M-1:0]                       m_wvalid,
    output logic [NUM_M-1:0]                       m_wready,
    input  logic [NUM_M*axi_warb_pkg::DATA_W-1:0]  m_wdata,
    input  logic [NUM_M-1:0]                       m_wlast,
    output logic [NUM_M-1:0]                       m_bvalid,
    input  logic [NUM_M-1:0]                       m_bready,
    output logic [ID_W-1:0]                        m_bid,
    output logic                                   m_bcomp,
    output logic                                   s_awvalid,
    input  logic                                   s_awready,
    output logic [ID_W-1:0]                        s_awid,
    output logic [axi_warb_pkg::ADDR_W-1:0]        s_awaddr,
    output logic [axi_warb_pkg::ATOP_W-1:0]        s_awatop,
    output logic                                   s_wvalid,
    input  logic                                   s_wready,
    output logic [axi_warb_pkg::DATA_W-1:0]        s_wdata,
    output logic                                   s_wlast,
    input  logic                                   s_bvalid,
    output logic                                   s_bready,
    input  logic [ID_W-1:0]                        s_bid,
    input  logic                                   s_bcomp,
    output logic                                   grant,
    output logic                                   busy
);
    import axi_warb_pkg::*;

`ifdef AXI_WARB_FIXED_PRIO_EN
    localparam logic FIXED = 1'b1;
`else
    localparam logic FIXED = 1'b0;
`endif

    warb_state_e      state;
    logic [CNT_W-1:0] beat_cnt;
    logic             rr_ptr;
    logic             arb_gnt;
    logic             aw_hs, w_hs, b_hs;

    assign aw_hs = s_awvalid && s_awready;
    assign w_hs  = s_wvalid  && s_wready;
    assign b_hs  = s_bvalid  && s_bready;

    rr_arb2 u_arb (
        .req        (m_awvalid),
        .ptr        (rr_ptr),
        .fixed_prio (FIXED),
        .grant      (arb_gnt)
    );

`ifdef AXI_WARB_FIXED_PRIO_EN
    assign rr_ptr = 1'b0;
`else
    // Hand the next tie to the other manager once a transaction completes.
    always_ff @(posedge clk) begin
        if (rst)                     rr_ptr <= 1'b0;
        else if (state == B && b_hs) rr_ptr <= ~grant;
    end
`endif

    // Transaction FSM with registered grant/busy and the W beat count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            grant    <= 1'b0;
            busy     <= 1'b0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (|m_awvalid) begin
                    grant    <= arb_gnt;
                    busy     <= 1'b1;
                    beat_cnt <= '0;
                    state    <= AW;
                end
                AW: if (aw_hs) state <= W;
                W: if (w_hs) begin
                    beat_cnt <= sat_inc(beat_cnt);
                    if (s_wlast) state <= B;
                end
                B: if (b_hs) begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Route only the active channel of the owning manager; all else stays 0.
    always_comb begin
        m_awready = '0;
        m_wready  = '0;
        m_bvalid  = '0;
        m_bid     = '0;
        m_bcomp   = 1'b0;
        s_awvalid = 1'b0;
        s_awid    = '0;
        s_awaddr  = '0;
        s_awatop  = '0;
        s_wvalid  = 1'b0;
        s_wdata   = '0;
        s_wlast   = 1'b0;
        s_bready  = 1'b0;
        case (state)
            AW: begin
                s_awvalid        = m_awvalid[grant];
                s_awid           = m_awid[grant*ID_W +: ID_W];
                s_awaddr         = m_awaddr[grant*ADDR_W +: ADDR_W];
                s_awatop         = m_awatop[grant*ATOP_W +: ATOP_W];
                m_awready[grant] = s_awready;
            end
            W: begin
                s_wvalid        = m_wvalid[grant];
                s_wdata         = m_wdata[grant*DATA_W +: DATA_W];
                s_wlast         = m_wlast[grant];
                m_wready[grant] = s_wready;
            end
            B: begin
                m_bvalid[grant] = s_bvalid;
                s_bready        = m_bready[grant];
                m_bid           = s_bid;
                m_bcomp         = s_bcomp;
            end
            default: ;
        endcase
    end

    // A fresh grant always starts with a cleared beat count.
    always_ff @(posedge clk) begin
        if (!rst && state == AW) assert (beat_cnt == '0);
    end

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Self-checking bench for axi_write_arbiter: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a
// transaction-phase reference model.
module tb_axi_write_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  m_awvalid = '0, m_awready;
    logic [7:0]  m_awid    = '0;
    logic [63:0] m_awaddr  = '0;
    logic [11:0] m_awatop  = '0;
    logic [1:0]  m_wvalid  = '0, m_wready;
    logic [63:0] m_wdata   = '0;
    logic [1:0]  m_wlast   = '0;
    logic [1:0]  m_bvalid;
    logic [1:0]  m_bready  = '0;
    logic [3:0]  m_bid;
    logic        m_bcomp;
    logic        s_awvalid, s_awready = 1'b0;
    logic [3:0]  s_awid;
    logic [31:0] s_awaddr;
    logic [5:0]  s_awatop;
    logic        s_wvalid, s_wready = 1'b0;
    logic [31:0] s_wdata;
    logic        s_wlast;
    logic        s_bvalid = 1'b0, s_bready;
    logic [3:0]  s_bid    = '0;
    logic        s_bcomp  = 1'b0;
    logic        grant, busy;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    axi_write_arbiter dut (
        .clk(clk), .rst(rst),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awid(m_awid),
        .m_awaddr(m_awaddr), .m_awatop(m_awatop),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wlast(m_wlast),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid), .m_bcomp(m_bcomp),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid),
        .s_awaddr(s_awaddr), .s_awatop(s_awatop),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wlast(s_wlast),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bcomp(s_bcomp),
        .grant(grant), .busy(busy)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: which phase of the single outstanding transaction we
    // are in (0 none, 1 address, 2 data, 3 response), who owns it, and whose
    // turn it is on a tie.
    int ph    = 0;
    bit own   = 0;
    bit turn  = 0;
    bit mlive = 0;

    always @(posedge clk) begin
        if (rst) begin
            ph = 0; own = 0; turn = 0; mlive = 1;
        end else if (mlive) begin
            case (ph)
                0: if (m_awvalid != 2'b00) begin
`ifdef AXI_WARB_FIXED_PRIO_EN
                    own = (m_awvalid == 2'b10);
`else
                    own = (m_awvalid == 2'b11) ? turn : (m_awvalid == 2'b10);
`endif
                    ph = 1;
                end
                1: if (m_awvalid[own] && s_awready) ph = 2;
                2: if (m_wvalid[own] && s_wready && m_wlast[own]) ph = 3;
                3: if (s_bvalid && m_bready[own]) begin ph = 0; turn = !own; end
                default: ph = 0;
            endcase
        end
    end

    // Compare every DUT output against the model mid-cycle.
    always @(negedge clk) begin
        logic [1:0]  e_awr, e_wr, e_bv;
        logic [42:0] e_saw;
        logic [33:0] e_sw;
        logic [4:0]  e_b;
        if (mlive) begin
            e_awr = '0; e_wr = '0; e_bv = '0;
            e_saw = '0; e_sw = '0; e_b = '0;
            if (ph == 1) begin
                e_awr[own] = s_awready;
                e_saw = {m_awvalid[own], m_awid[own*4 +: 4], m_awaddr[own*32 +: 32], m_awatop[own*6 +: 6]};
            end
            if (ph == 2) begin
                e_wr[own] = s_wready;
                e_sw = {m_wvalid[own], m_wdata[own*32 +: 32], m_wlast[own]};
            end
            if (ph == 3) begin
                e_bv[own] = s_bvalid;
                e_b = {s_bcomp, s_bid};
            end
            chk("m_awready", {62'd0, m_awready}, {62'd0, e_awr});
            chk("m_wready",  {62'd0, m_wready},  {62'd0, e_wr});
            chk("m_bvalid",  {62'd0, m_bvalid},  {62'd0, e_bv});
            chk("m_b_fields", {59'd0, m_bcomp, m_bid}, {59'd0, e_b});
            chk("s_aw_bundle", {21'd0, s_awvalid, s_awid, s_awaddr, s_awatop}, {21'd0, e_saw});
            chk("s_w_bundle",  {30'd0, s_wvalid, s_wdata, s_wlast}, {30'd0, e_sw});
            chk("s_bready", {63'd0, s_bready}, {63'd0, (ph == 3) && m_bready[own]});
            chk("busy", {63'd0, busy}, {63'd0, ph != 0});
            if (ph != 0) chk("grant", {63'd0, grant}, {63'd0, own});
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear();
        m_awvalid = '0; m_wvalid = '0; m_wlast = '0; m_bready = '0;
        s_awready = 0; s_wready = 0; s_bvalid = 0; s_bid = '0; s_bcomp = 0;
    endtask

    task automatic do_reset();
        clear();
        rst = 1; tick(); tick();
        rst = 0;
    endtask

    // From the address phase with the owner's awvalid held: one-beat write and response.
    task automatic finish_txn(input bit m);
        s_awready = 1; tick();
        s_awready = 0;
        m_wvalid = '0; m_wvalid[m] = 1; m_wlast = '0; m_wlast[m] = 1; s_wready = 1; tick();
        m_wvalid = '0; m_wlast = '0; s_wready = 0;
        s_bvalid = 1; m_bready = 2'b11; tick();
        s_bvalid = 0; m_bready = '0;
    endtask

    initial begin
        bit exp2;
        // Single manager 0 write: 4 beats, response id 3.
        do_reset(); #1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_grant", {63'd0, grant}, 64'd0);
        chk("rst_readies", {58'd0, m_awready, m_wready, m_bvalid}, 64'd0);
        chk("rst_s_valids", {61'd0, s_awvalid, s_wvalid, s_bready}, 64'd0);
        m_awvalid = 2'b01; m_awaddr = {32'h0, 32'h100}; m_awid = 8'h05; #1;
        chk("arb_latency", {63'd0, s_awvalid}, 64'd0);
        tick(); #1;
        chk("t1_awaddr", {32'd0, s_awaddr}, 64'h100);
        chk("t1_awid", {60'd0, s_awid}, 64'h5);
        chk("t1_busy", {63'd0, busy}, 64'd1);
        s_awready = 1; #1;
        chk("t1_awready", {62'd0, m_awready}, 64'd1);
        tick();
        m_awvalid = '0; s_awready = 0;
        for (int b = 0; b < 4; b++) begin
            m_wvalid = 2'b01; m_wdata = {32'h0, 32'hA0 + b}; m_wlast = (b == 3) ? 2'b01 : 2'b00;
            s_wready = 1; #1;
            chk("t1_s_wvalid", {63'd0, s_wvalid}, 64'd1);
            chk("t1_wdata", {32'd0, s_wdata}, 64'hA0 + b);
            tick();
        end
        clear();
        s_bvalid = 1; s_bid = 4'd3; s_bcomp = 1; m_bready = 2'b01; #1;
        chk("t1_bvalid", {62'd0, m_bvalid}, 64'd1);
        chk("t1_bid", {60'd0, m_bid}, 64'd3);
        tick(); clear(); #1;
        chk("t1_busy_drop", {63'd0, busy}, 64'd0);

        // Simultaneous requests from reset.
        do_reset();
        m_awvalid = 2'b11; tick(); #1;
        chk("t2_first_grant", {63'd0, grant}, 64'd0);
        finish_txn(1'b0); #1;
        chk("t2_idle_gap", {63'd0, busy}, 64'd0);
        tick(); #1;
`ifdef AXI_WARB_FIXED_PRIO_EN
        exp2 = 1'b0;
`else
        exp2 = 1'b1;
`endif
        chk("t2_second_grant", {63'd0, grant}, {63'd0, exp2});
        chk("t2_second_busy", {63'd0, busy}, 64'd1);
        finish_txn(exp2);
        clear();

        // W issued before AW is granted must stall.
        do_reset();
        m_awvalid = 2'b10; m_wvalid = 2'b10; s_wready = 1; #1;
        chk("t3_wready_idle", {62'd0, m_wready}, 64'd0);
        tick(); #1;
        chk("t3_wready_aw", {62'd0, m_wready}, 64'd0);
        chk("t3_swvalid_aw", {63'd0, s_wvalid}, 64'd0);
        s_awready = 1; tick(); s_awready = 0; #1;
        chk("t3_wready_w", {62'd0, m_wready}, 64'b10);
        chk("t3_swvalid_w", {63'd0, s_wvalid}, 64'd1);

        // Subordinate stalls AW; the other manager's request is ignored.
        do_reset();
        m_awvalid = 2'b01; tick();
        m_awvalid = 2'b11; s_awready = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t4_hold_valid", {63'd0, s_awvalid}, 64'd1);
            chk("t4_hold_grant", {63'd0, grant}, 64'd0);
            chk("t4_awready", {62'd0, m_awready}, 64'd0);
            tick();
        end

        // Reset in the middle of the data phase.
        do_reset();
        m_awvalid = 2'b01; tick();
        s_awready = 1; tick();
        m_awvalid = '0; s_awready = 0;
        m_wvalid = 2'b01; s_wready = 1; tick(); tick();
        rst = 1; tick();
        rst = 0; s_bvalid = 1; s_bid = 4'd3; m_bready = 2'b11; #1;
        chk("t5_busy", {63'd0, busy}, 64'd0);
        chk("t5_grant", {63'd0, grant}, 64'd0);
        chk("t5_readies", {58'd0, m_awready, m_wready, m_bvalid}, 64'd0);
        chk("t5_s_out", {59'd0, s_wvalid, s_bready, m_bid[2:0]}, 64'd0);
        clear();
        m_awvalid = 2'b10; m_awaddr = {32'h200, 32'h0}; tick(); #1;
        chk("t5_new_grant", {63'd0, grant}, 64'd1);
        chk("t5_new_addr", {32'd0, s_awaddr}, 64'h200);
        finish_txn(1'b1);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            tick();
            rst       = ($urandom_range(0, 299) == 0);
            m_awvalid = 2'($urandom);
            m_awid    = 8'($urandom);
            m_awaddr  = {$urandom, $urandom};
            m_awatop  = 12'($urandom);
            m_wvalid  = 2'($urandom);
            m_wdata   = {$urandom, $urandom};
            m_wlast   = 2'($urandom_range(0, 3));
            m_bready  = 2'($urandom);
            s_awready = ($urandom_range(0, 3) != 0);
            s_wready  = ($urandom_range(0, 3) != 0);
            s_bvalid  = ($urandom_range(0, 2) != 0);
            s_bid     = 4'($urandom);
            s_bcomp   = 1'($urandom);
        end
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
